// File: rtl/regfile_sb_if.sv
// Bundle of read, reserve, writeback and status signals for the scoreboarded register file.
// The slave modport is the register file; the master modport is the pipeline that drives it.
interface regfile_sb_if #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rs_addr_i;
    logic [NRD*XLEN-1:0] rs_data_o;
    logic [NRD-1:0]      rs_valid_o;
    logic                rsv_en_i;
    logic [AW-1:0]       rsv_addr_i;
    logic                rsv_ready_o;
    logic                wb0_en_i;
    logic [AW-1:0]       wb0_addr_i;
    logic [XLEN-1:0]     wb0_data_i;
    logic                wb1_en_i;
    logic [AW-1:0]       wb1_addr_i;
    logic [XLEN-1:0]     wb1_data_i;
    logic                flush_i;
    logic                sb_err_o;

    modport master (
        output rs_addr_i, rsv_en_i, rsv_addr_i,
        output wb0_en_i, wb0_addr_i, wb0_data_i,
        output wb1_en_i, wb1_addr_i, wb1_data_i, flush_i,
        input  rs_data_o, rs_valid_o, rsv_ready_o, sb_err_o
    );

    modport slave (
        input  rs_addr_i, rsv_en_i, rsv_addr_i,
        input  wb0_en_i, wb0_addr_i, wb0_data_i,
        input  wb1_en_i, wb1_addr_i, wb1_data_i, flush_i,
        output rs_data_o, rs_valid_o, rsv_ready_o, sb_err_o
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with a per-register pending-write counter (scoreboard) and same-cycle writeback bypass.
// Register 0 is hardwired to zero and never pending.
module regfile_sb #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int CNTW  = 2
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam int SW = CNTW + 2;
    localparam logic [CNTW-1:0] MAX = '1;

    logic [XLEN-1:0] regs     [NREGS];
    logic [CNTW-1:0] cnt      [NREGS];
    logic [CNTW-1:0] cnt_next [NREGS];
    logic [NREGS-1:0] underflow;
    logic err;
    logic rsv_ready;
    logic rsv_take;

    // A full counter blocks new reservations even if a release lands this cycle.
    assign rsv_ready = !rst || (bus.rsv_addr_i == '0) || (cnt[bus.rsv_addr_i] != MAX);
    assign rsv_take  = rst && bus.rsv_en_i && rsv_ready && (bus.rsv_addr_i != '0);

    for (genvar i = 0; i < NREGS; i++) begin : g_cnt
        logic          hit0;
        logic          hit1;
        logic          take;
        logic [SW-1:0] sum;

        assign hit0 = bus.wb0_en_i && (bus.wb0_addr_i == AW'(i)) && (i != 0);
        assign hit1 = bus.wb1_en_i && (bus.wb1_addr_i == AW'(i)) && (i != 0);
        assign take = rsv_take && (bus.rsv_addr_i == AW'(i));
        // Two extra bits make the sum a signed value whose MSB flags a release without a pending write.
        assign sum  = {2'b00, cnt[i]} + SW'(take) - SW'(hit0) - SW'(hit1);
        assign underflow[i] = sum[SW-1];
        assign cnt_next[i]  = sum[SW-1] ? '0 : sum[CNTW-1:0];
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            hit0;
        logic            hit1;
        logic [XLEN-1:0] data;
        logic            valid;

        assign addr = bus.rs_addr_i[k*AW +: AW];
        assign hit0 = bus.wb0_en_i && (bus.wb0_addr_i == addr);
        assign hit1 = bus.wb1_en_i && (bus.wb1_addr_i == addr);

        // Bypass in-flight writebacks; the last outstanding write makes the value final unless re-reserved.
        always_comb begin
            data  = '0;
            valid = 1'b1;
            if (rst && addr != '0) begin
                if (hit1)      data = bus.wb1_data_i;
                else if (hit0) data = bus.wb0_data_i;
                else           data = regs[addr];
                valid = (cnt[addr] == '0) ||
                        ((cnt[addr] == CNTW'(1)) && (hit0 || hit1) &&
                         !(rsv_take && bus.rsv_addr_i == addr));
            end
        end

        assign bus.rs_data_o[k*XLEN +: XLEN] = data;
        assign bus.rs_valid_o[k]             = valid;
    end

    // wb1 is written after wb0 so it wins when both target the same register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
            err <= 1'b0;
        end else begin
            if (bus.wb0_en_i && bus.wb0_addr_i != '0) regs[bus.wb0_addr_i] <= bus.wb0_data_i;
            if (bus.wb1_en_i && bus.wb1_addr_i != '0) regs[bus.wb1_addr_i] <= bus.wb1_data_i;
            for (int i = 0; i < NREGS; i++) begin
                cnt[i] <= bus.flush_i ? '0 : cnt_next[i];
            end
            if (!bus.flush_i && (|underflow)) err <= 1'b1;
        end
    end

    assign bus.rsv_ready_o = rsv_ready;
    assign bus.sb_err_o    = err;
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios then random traffic, all checked against an array-based model.
module tb_regfile_sb;
    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int CNTW  = 2;
    localparam int AW    = $clog2(NREGS);
    localparam int MAX   = (1 << CNTW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [XLEN-1:0] m_reg [NREGS];
    int              m_cnt [NREGS];
    bit              m_err;
    int              errors = 0;
    int              checks = 0;
    int              cyc    = 0;

    function automatic int hits(int a);
        return int'(bus.wb0_en_i && int'(bus.wb0_addr_i) == a) +
               int'(bus.wb1_en_i && int'(bus.wb1_addr_i) == a);
    endfunction

    function automatic bit exp_ready();
        return !rst || bus.rsv_addr_i == '0 || m_cnt[bus.rsv_addr_i] < MAX;
    endfunction

    // Register index whose reservation is accepted this cycle, or 0 when none.
    function automatic int accepted_addr();
        if (rst && bus.rsv_en_i && exp_ready() && bus.rsv_addr_i != '0) return int'(bus.rsv_addr_i);
        return 0;
    endfunction

    task automatic check(string tag, logic [XLEN-1:0] obs, logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        int a, h, acc;
        logic [XLEN-1:0] ed;
        bit ev;
        acc = accepted_addr();
        for (int k = 0; k < NRD; k++) begin
            a = int'(bus.rs_addr_i[k*AW +: AW]);
            h = hits(a);
            if (!rst || a == 0) begin
                ed = '0;
                ev = 1'b1;
            end else begin
                if (bus.wb1_en_i && int'(bus.wb1_addr_i) == a)      ed = bus.wb1_data_i;
                else if (bus.wb0_en_i && int'(bus.wb0_addr_i) == a) ed = bus.wb0_data_i;
                else                                                ed = m_reg[a];
                ev = (m_cnt[a] == 0) || (m_cnt[a] == 1 && h >= 1 && acc != a);
            end
            check($sformatf("cyc%0d rd%0d_data", cyc, k), bus.rs_data_o[k*XLEN +: XLEN], ed);
            check($sformatf("cyc%0d rd%0d_valid", cyc, k), XLEN'(bus.rs_valid_o[k]), XLEN'(ev));
        end
        check($sformatf("cyc%0d rsv_ready", cyc), XLEN'(bus.rsv_ready_o), XLEN'(exp_ready()));
        check($sformatf("cyc%0d sb_err", cyc), XLEN'(bus.sb_err_o), XLEN'(m_err));
    endtask

    task automatic update_model();
        int acc, n;
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                m_reg[i] = '0;
                m_cnt[i] = 0;
            end
            m_err = 1'b0;
        end else begin
            acc = accepted_addr();
            for (int a = 1; a < NREGS; a++) begin
                n = m_cnt[a] + int'(a == acc) - hits(a);
                if (bus.flush_i) m_cnt[a] = 0;
                else if (n < 0) begin
                    m_cnt[a] = 0;
                    m_err    = 1'b1;
                end else m_cnt[a] = n;
            end
            if (bus.wb0_en_i && bus.wb0_addr_i != '0) m_reg[bus.wb0_addr_i] = bus.wb0_data_i;
            if (bus.wb1_en_i && bus.wb1_addr_i != '0) m_reg[bus.wb1_addr_i] = bus.wb1_data_i;
        end
    endtask

    // Drive one cycle of inputs, check outputs at the falling edge, then advance the model on the rising edge.
    task automatic apply_stimulus(bit r, int rd0, int rd1, bit ren, int raddr,
                                  bit w0en, int w0a, logic [XLEN-1:0] w0d,
                                  bit w1en, int w1a, logic [XLEN-1:0] w1d, bit fl);
        rst                   = r;
        bus.rs_addr_i[0+:AW]  = AW'(rd0);
        bus.rs_addr_i[AW+:AW] = AW'(rd1);
        bus.rsv_en_i          = ren;
        bus.rsv_addr_i        = AW'(raddr);
        bus.wb0_en_i          = w0en;
        bus.wb0_addr_i        = AW'(w0a);
        bus.wb0_data_i        = w0d;
        bus.wb1_en_i          = w1en;
        bus.wb1_addr_i        = AW'(w1a);
        bus.wb1_data_i        = w1d;
        bus.flush_i           = fl;
        @(negedge clk);
        check_output();
        @(posedge clk);
        update_model();
        #1;
        cyc++;
    endtask

    initial begin
        rst           = 1'b0;
        bus.rs_addr_i = '0;
        bus.rsv_en_i  = 1'b0;
        bus.rsv_addr_i = '0;
        bus.wb0_en_i  = 1'b0;
        bus.wb0_addr_i = '0;
        bus.wb0_data_i = '0;
        bus.wb1_en_i  = 1'b0;
        bus.wb1_addr_i = '0;
        bus.wb1_data_i = '0;
        bus.flush_i   = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            m_reg[i] = '0;
            m_cnt[i] = 0;
        end
        m_err = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with busy inputs: outputs forced to their reset values.
        apply_stimulus(0, 3, 4, 1, 6, 1, 3, 64'h1234, 1, 4, 64'h5678, 0);
        apply_stimulus(0, 6, 0, 1, 6, 1, 6, 64'h9, 0, 0, 0, 0);

        $display("[TB] reset state: reading all registers");
        for (int i = 0; i < NREGS; i += 2)
            apply_stimulus(1, i, i + 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] reserve then writeback with bypass");
        apply_stimulus(1, 5, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 5, 0, 0, 0, 1, 5, 64'hDEAD, 0, 0, 0, 0);
        apply_stimulus(1, 5, 5, 0, 5, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] counter saturation on x7");
        for (int i = 0; i < MAX; i++)
            apply_stimulus(1, 7, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 7, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 7, 0, 0, 7, 1, 7, 64'h77, 0, 0, 0, 0);
        apply_stimulus(1, 7, 0, 0, 7, 1, 7, 64'h78, 0, 0, 0, 0);
        apply_stimulus(1, 7, 0, 0, 7, 0, 0, 0, 1, 7, 64'h79, 0);
        apply_stimulus(1, 7, 7, 0, 7, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] dual writeback to x3");
        apply_stimulus(1, 3, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 3, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 3, 3, 0, 0, 1, 3, 64'h1, 1, 3, 64'h2, 0);
        apply_stimulus(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] underflow on x9 is sticky");
        apply_stimulus(1, 9, 0, 0, 0, 1, 9, 64'h99, 0, 0, 0, 0);
        apply_stimulus(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        apply_stimulus(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] flush with concurrent writeback on x4");
        apply_stimulus(1, 4, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 4, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 4, 0, 0, 0, 0, 0, 0, 1, 4, 64'h55, 1);
        apply_stimulus(1, 4, 4, 0, 4, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] random traffic");
        for (int n = 0; n < 800; n++) begin
            apply_stimulus($urandom_range(63) != 0,
                           $urandom_range(7), $urandom_range(7),
                           $urandom_range(1) == 1, $urandom_range(7),
                           $urandom_range(2) == 0, $urandom_range(7), {$urandom, $urandom},
                           $urandom_range(2) == 0, $urandom_range(7), {$urandom, $urandom},
                           $urandom_range(15) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
